// File: rtl/instr_exec_unit.sv
// ============================================================================
// Module      : instr_exec_unit (with package instr_register_pkg)
// Description : Single-issue execute stage. It takes an instruction word plus
//               a tag and holds a tagged 64-bit result under ready/valid.
//               The optional build macro INSTR_EXEC_ITER_DIV_EN selects an
//               iterative restoring divider for DIV/MOD.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_register_pkg;
    typedef enum logic [2:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
    typedef logic signed [31:0] operand_t;
    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;
endpackage

module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  instruction_t        instruction_word,
    input  logic [4:0]          in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [63:0]  out_result,
    output logic [4:0]          out_tag,
    output opcode_t             out_opc,
    output logic                out_div_zero
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
`ifdef INSTR_EXEC_ITER_DIV_EN
        DIV_BUSY = 2'd1,
`endif
        DONE     = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_valid;
    logic signed [63:0]  r_result;
    logic [4:0]          r_tag;
    opcode_t             r_opc;
    logic                r_div_zero;

    logic signed [63:0]  w_a64;
    logic signed [63:0]  w_b64;
    logic signed [63:0]  w_res;
    logic                w_dz;
    logic                w_is_div;

    assign w_a64    = {{32{instruction_word.op_a[31]}}, instruction_word.op_a};
    assign w_b64    = {{32{instruction_word.op_b[31]}}, instruction_word.op_b};
    assign w_is_div = (instruction_word.opc == DIV) || (instruction_word.opc == MOD);

    // Single-cycle result for everything the iterative path does not handle.
    always_comb begin
        w_res = '0;
        w_dz  = 1'b0;
        case (instruction_word.opc)
            ZERO:  w_res = '0;
            PASSA: w_res = w_a64;
            PASSB: w_res = w_b64;
            ADD:   w_res = w_a64 + w_b64;
            SUB:   w_res = w_a64 - w_b64;
            MULT:  w_res = w_a64 * w_b64;
            DIV, MOD: begin
                if (instruction_word.op_b == '0) begin
                    w_dz = 1'b1;
                end else begin
`ifndef INSTR_EXEC_ITER_DIV_EN
                    w_res = (instruction_word.opc == DIV) ? (w_a64 / w_b64) : (w_a64 % w_b64);
`endif
                end
            end
            default: w_res = '0;
        endcase
    end

`ifdef INSTR_EXEC_ITER_DIV_EN
    localparam int c_cnt_w = $clog2(DIV_ITERS + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV_ITERS - 1);

    logic [c_cnt_w-1:0]  r_cnt;
    logic [31:0]         r_quo;
    logic [31:0]         r_rem;
    logic [31:0]         r_dvs;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_is_mod;

    logic [31:0]         w_mag_a;
    logic [31:0]         w_mag_b;
    logic [32:0]         w_shift;
    logic [32:0]         w_diff;
    logic                w_fits;
    logic [31:0]         w_rem_nx;
    logic [31:0]         w_quo_nx;
    logic signed [63:0]  w_q64;
    logic signed [63:0]  w_r64;
    logic signed [63:0]  w_div_res;

    assign w_mag_a = instruction_word.op_a[31] ? 32'(-instruction_word.op_a) : 32'(instruction_word.op_a);
    assign w_mag_b = instruction_word.op_b[31] ? 32'(-instruction_word.op_b) : 32'(instruction_word.op_b);

    // Partial remainder stays below the divisor (<= 2^31), so the borrow bit
    // of the 33-bit trial subtraction is the restore decision.
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_fits    = !w_diff[32];
    assign w_rem_nx  = w_fits ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_nx  = {r_quo[30:0], w_fits};
    assign w_q64     = {32'd0, w_quo_nx};
    assign w_r64     = {32'd0, w_rem_nx};
    assign w_div_res = r_is_mod ? (r_neg_r ? -w_r64 : w_r64)
                                : (r_neg_q ? -w_q64 : w_q64);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_result   <= '0;
            r_tag      <= '0;
            r_opc      <= ZERO;
            r_div_zero <= 1'b0;
`ifdef INSTR_EXEC_ITER_DIV_EN
            r_cnt      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dvs      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_is_mod   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_tag <= in_tag;
                        r_opc <= instruction_word.opc;
`ifdef INSTR_EXEC_ITER_DIV_EN
                        if (w_is_div && !w_dz) begin
                            r_state  <= DIV_BUSY;
                            r_cnt    <= '0;
                            r_quo    <= w_mag_a;
                            r_rem    <= '0;
                            r_dvs    <= w_mag_b;
                            r_neg_q  <= instruction_word.op_a[31] ^ instruction_word.op_b[31];
                            r_neg_r  <= instruction_word.op_a[31];
                            r_is_mod <= (instruction_word.opc == MOD);
                        end else
`endif
                        begin
                            r_result   <= w_res;
                            r_div_zero <= w_dz && w_is_div;
                            r_valid    <= 1'b1;
                            r_state    <= DONE;
                        end
                    end
                end
`ifdef INSTR_EXEC_ITER_DIV_EN
                DIV_BUSY: begin
                    r_quo <= w_quo_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last) begin
                        r_result   <= w_div_res;
                        r_div_zero <= 1'b0;
                        r_valid    <= 1'b1;
                        r_state    <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready     = (r_state == IDLE) && !reset;
    assign out_valid    = r_valid;
    assign out_result   = r_result;
    assign out_tag      = r_tag;
    assign out_opc      = r_opc;
    assign out_div_zero = r_div_zero;

endmodule

`default_nettype wire
